// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with registered read (latency 1 or 2),
// read-valid pulse and a zero-fill clear engine run after reset or on request.
module ram_sp_param #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              clr_start,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_issue;

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The clear engine shares the single write port; in CLEAR it owns it outright.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = addr;
    wr_data   = i_data;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        wr_en    = cs && we;
        rd_issue = cs && re && !we;
        if (clr_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = '0;
        if (clr_addr == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      if (clr_addr == '1) clr_addr <= '0;
      else                clr_addr <= clr_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_data  <= '0;
          o_valid <= 1'b0;
        end else begin
          o_valid <= rd_issue;
          if (rd_issue) o_data <= mem[addr];
        end
      end
    end else if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] stg_data;
      logic              stg_valid;

      // Second stage runs regardless of FSM state so reads issued before a clear still finish.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_data  <= '0;
          stg_valid <= 1'b0;
          o_data    <= '0;
          o_valid   <= 1'b0;
        end else begin
          stg_valid <= rd_issue;
          if (rd_issue) stg_data <= mem[addr];
          o_valid <= stg_valid;
          if (stg_valid) o_data <= stg_data;
        end
      end
    end else begin : g_bad_lat
      $error("ram_sp_param: READ_LAT must be 1 or 2");
    end
  endgenerate

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous RAM with chip select, separate write and read strobes, and a registered read path with selectable latency. It adds an `o_valid` read-valid pulse and a hardware clear state machine that zero-fills the array after reset or on command. It is the generalised successor of the fixed 16x8 RAM blocks and is the memory primitive for datapath buffers and register files.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 4: address width in bits. Depth is `2**ADDR_W` words, derived internally and not overridable.
- `READ_LAT`, default 1: read latency in clocks. Only 1 and 2 are legal; any other value is an elaboration error.
- `CLEAR_ON_RESET`, default 1: when 1, a zero-fill runs automatically after reset; when 0, the array is uninitialised after reset.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select; no access occurs unless it is high.
- `we`  in  1  write strobe.
- `re`  in  1  read strobe.
- `addr`  in  ADDR_W  word address.
- `i_data`  in  DATA_W  write data.
- `clr_start`  in  1  requests a zero-fill; sampled only in IDLE.
- `o_data`  out  DATA_W  registered read data; holds its value between reads.
- `o_valid`  out  1  one-cycle pulse when `o_data` carries a new read result.
- `busy`  out  1  high while a clear is in progress; all accesses are ignored.

## Operation
- FSM states:
  - IDLE: accesses are served.
  - CLEAR: internal counter `clr_addr` walks 0 to DEPTH-1 and writes 0 to one word per clock.
- Transitions:
  - IDLE to CLEAR when `clr_start` is high at an edge.
  - CLEAR to IDLE on the edge that writes word DEPTH-1.
  - `clr_start` is ignored in CLEAR.
- Write: `cs && we` at an edge in IDLE writes `i_data` to `Mem[addr]`.
- Read: `cs && re && !we` at an edge in IDLE issues a read of `Mem[addr]`.
- Simultaneous `we` and `re`: the write wins. No read is issued and `o_valid` does not pulse.
- Access in the same cycle as `clr_start`: the access is performed first, and the clear begins on the following edge.
- While `busy` is high:
  - `cs`, `we` and `re` are ignored. No write occurs and no read is issued.
  - The bench must not rely on any queuing of these requests.
- In-flight reads: a read issued before CLEAR is entered completes normally with pre-clear data, including the second stage when `READ_LAT`=2.
- Read-after-write: a read of an address issued on the edge after a write to it returns the new data.
- Reset (`rst_n` low, asynchronous):
  - `o_data` = 0 and `o_valid` = 0.
  - Read pipeline flushed and `clr_addr` = 0.
  - State = CLEAR if `CLEAR_ON_RESET`=1, otherwise IDLE. `busy` equals `CLEAR_ON_RESET` during reset.
  - Array contents are not reset asynchronously.
- Reset asserted mid-clear: the clear restarts from address 0 after deassertion (if `CLEAR_ON_RESET`=1) or is abandoned (if 0).
- `clr_addr` width is ADDR_W. The terminal condition is `clr_addr == DEPTH-1`, with no wrap back to 0 while in CLEAR.

## Timing
- Reads, with the request sampled at edge k:
  - `READ_LAT`=1: `o_data` and `o_valid` are updated at edge k.
  - `READ_LAT`=2: the data is staged at edge k and presented at edge k+1.
  - `o_valid` is high for exactly one cycle per issued read.
- Back-to-back reads on consecutive edges produce consecutive `o_valid` pulses with no bubbles, at one result per clock.
- Writes take effect at the sampling edge; there is no output activity.
- Commanded clear:
  - `clr_start` sampled at edge k sets `busy` high after edge k.
  - Zero writes occur at edges k+1 through k+DEPTH.
  - `busy` falls after edge k+DEPTH.
  - The first serviced access is at edge k+DEPTH+1.
- Reset clear: after `rst_n` deasserts, zero writes occur at the first DEPTH edges, and `busy` falls after the DEPTH-th edge.

## Test plan
- Defaults, reset clear: release reset, count edges while `busy` is high -> expect exactly 16. Then read addresses 0 and 15 -> `o_data`=00 with a single `o_valid` pulse each.
- Write and read back: write aa to address 0 and 55 to address 7, then read 7, 0, 7 back to back -> `o_data` 55, aa, 55 on three consecutive cycles with `o_valid` high continuously for 3 cycles.
- `READ_LAT`=2, `DATA_W`=16, `ADDR_W`=6: write beef to address 63, read it -> `o_data`=beef and `o_valid` high one cycle later than in the `READ_LAT`=1 build.
- Write/read collision and ignore rules:
  - `cs`=1 with `we`=1, `re`=1, `addr`=1, `i_data`=2a -> no `o_valid` pulse, then a read of address 1 returns 2a.
  - `cs`=0 with `we`=1 -> memory unchanged.
- Commanded clear with blocked access: fill address 3 with 5a, pulse `clr_start`, and attempt a write of ff to address 3 while `busy` is high -> `busy` is high for 16 cycles, then a read of address 3 returns 00.
- Reset mid-operation: assert `rst_n` low 5 cycles into a clear with a read in flight -> `o_data`=00, `o_valid`=0, and `busy`=1 immediately. After release, `busy` stays high for a full 16 edges.
